immed_encoder: RTL and testbench
================================

Name: immed_encoder

Overview:
- Inverse of the core's immediate generator: packs a 32-bit immediate into the I/S/B/U/J bit fields of a RISC-V instruction word.
- Non-immediate fields (opcode, rd, rs1, rs2, funct) come from a template word.
- Checks that the immediate is representable in the selected format.
- Used by the debug/patch path and the self-test instruction builder; two-stage elastic pipeline with valid/ready on both sides.

Parameters:
CNT_W, 16, width of the saturating error counter ERR_COUNT.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST_N  input  1  synchronous reset, active-low
IN_VALID  input  1  request valid
IN_READY  output  1  request accepted when IN_VALID && IN_READY
FMT  input  3  0=I, 1=S, 2=B, 3=U, 4=J; 5-7 illegal
IMM  input  32  immediate value (byte offset for B/J)
BASE  input  32  template instruction; immediate bit positions ignored
OUT_VALID  output  1  result valid
OUT_READY  input  1  result consumed when OUT_VALID && OUT_READY
INSTRUCT  output  32  packed instruction
ERR  output  1  result is an error substitute
ERR_CODE  output  2  0=none, 1=range, 2=misaligned, 3=bad format
ERR_COUNT  output  CNT_W  saturating count of errored results consumed

Behaviour:
- Reset (RST_N=0 at a rising edge): both stage valids clear; OUT_VALID=0, INSTRUCT=0, ERR=0, ERR_CODE=0, ERR_COUNT=0. IN_READY=0 while RST_N=0. In-flight items are dropped, with no partial output.
- Pipeline:
  - S1 registers FMT/IMM/BASE and computes ERR_CODE.
  - S2 registers the packed INSTRUCT/ERR/ERR_CODE, which drive the outputs directly.
  - Latency is 2 cycles from acceptance to OUT_VALID when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - s2_adv = !s2_valid || OUT_READY.
  - s1_adv = s1_valid && s2_adv.
  - IN_READY = RST_N && (!s1_valid || s2_adv).
  - Outputs are held stable while OUT_VALID && !OUT_READY.
  - Simultaneous output consume and input accept in the same cycle is legal and must not lose or duplicate items.
  - Order is preserved. Maximum 2 items in flight.
- Error check, in priority order:
  - Bad format: FMT>4 → code 3.
  - Misaligned: B or J with IMM[0]=1 → code 2.
  - Range:
    - I/S: IMM[31:11] not all equal.
    - B: IMM[31:12] not all equal.
    - J: IMM[31:20] not all equal.
    - U: IMM[11:0]≠0.
    - Any of these → code 1.
- Packing (bits not listed come from BASE):
  - I: [31:20]=IMM[11:0].
  - S: [31:25]=IMM[11:5]; [11:7]=IMM[4:0].
  - B: [31]=IMM[12]; [30:25]=IMM[10:5]; [11:8]=IMM[4:1]; [7]=IMM[11].
  - U: [31:12]=IMM[31:12].
  - J: [31]=IMM[20]; [30:21]=IMM[10:1]; [20]=IMM[11]; [19:12]=IMM[19:12].
- On error: INSTRUCT=32'h0000_0013 (addi x0,x0,0), ERR=1.
- Round-trip property: for every non-error result, decoding INSTRUCT in the same format returns IMM exactly.
- ERR_COUNT increments on OUT_VALID && OUT_READY && ERR. It saturates at all-ones and never wraps. A stalled errored result counts once.
- Outputs are undefined-free: INSTRUCT keeps its last value when OUT_VALID=0.

Test Plan:
1. FMT=0, BASE=32'h0000_0013, IMM=32'hFFFF_F800, OUT_READY=1 → INSTRUCT=32'h8000_0013, ERR=0, OUT_VALID exactly 2 cycles after acceptance. Then IMM=32'h0000_0800 → ERR=1, ERR_CODE=1, INSTRUCT=32'h0000_0013.
2. FMT=2, BASE=32'h0000_0063, IMM=32'h0000_0FFE → INSTRUCT=32'h7E00_0FE3. FMT=3, BASE=32'h0000_0537, IMM=32'h1234_5000 → INSTRUCT=32'h1234_5537.
3. Error codes:
   - FMT=4, IMM=32'h0000_0001 → ERR_CODE=2.
   - FMT=7 with any IMM → ERR_CODE=3.
   - FMT=2, IMM=32'h0000_1001 → ERR_CODE=2 (misaligned beats range).
   - ERR_COUNT=3 after all three are consumed.
4. Backpressure: OUT_READY=0, drive 3 back-to-back valid requests → first two accepted, IN_READY=0 on the third. OUT_READY=1 for 3 cycles → three results in order, each appearing once, with the third accepted on the first release cycle.
5. Reset mid-stream: 2 items in flight, RST_N=0 for one cycle → next cycle OUT_VALID=0, ERR_COUNT=0, IN_READY=0 during reset. The first request after release completes in 2 cycles.
6. Saturation: with CNT_W=2, consume 5 errored results → ERR_COUNT sticks at 2'b11. A random 10k-request round-trip against a reference decoder shows zero mismatches.

Source files
------------

// File: rtl/immed_encoder_if.sv
// Request/result bundle for the immediate encoder.
// Handshake: a transfer happens on a rising CLK edge where VALID && READY are
// both high. A producer holding VALID keeps its payload stable until the
// transfer. READY may depend combinationally on the consumer's state, but
// never on the producer's VALID.
interface immed_encoder_if #(
    parameter int CNT_W = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [2:0]       FMT;
    logic [31:0]      IMM;
    logic [31:0]      BASE;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [31:0]      INSTRUCT;
    logic             ERR;
    logic [1:0]       ERR_CODE;
    logic [CNT_W-1:0] ERR_COUNT;

    modport master (
        output IN_VALID, FMT, IMM, BASE, OUT_READY,
        input  IN_READY, OUT_VALID, INSTRUCT, ERR, ERR_CODE, ERR_COUNT
    );

    modport slave (
        input  IN_VALID, FMT, IMM, BASE, OUT_READY,
        output IN_READY, OUT_VALID, INSTRUCT, ERR, ERR_CODE, ERR_COUNT
    );
endinterface

// File: rtl/immed_encoder.sv
// Packs a 32-bit immediate into the I/S/B/U/J fields of a RISC-V instruction
// taken from a template word. Two-stage elastic pipeline: S1 holds the request
// and its error code, S2 holds the packed result that drives the outputs.
module immed_encoder #(
    parameter int CNT_W = 16
) (
    input logic             CLK,
    input logic             RST_N,
    immed_encoder_if.slave  bus
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013; // addi x0,x0,0

    // Error code: bad format, then misalignment, then range.
    function automatic logic [1:0] calc_code(input logic [2:0] fmt, input logic [31:0] imm);
        logic bad_range;
        bad_range = 1'b0;
        case (fmt)
            3'd0, 3'd1: bad_range = !((&imm[31:11]) || !(|imm[31:11]));
            3'd2:       bad_range = !((&imm[31:12]) || !(|imm[31:12]));
            3'd3:       bad_range = |imm[11:0];
            3'd4:       bad_range = !((&imm[31:20]) || !(|imm[31:20]));
            default:    bad_range = 1'b0;
        endcase
        if (fmt > 3'd4)                                  return 2'd3;
        else if ((fmt == 3'd2 || fmt == 3'd4) && imm[0]) return 2'd2;
        else if (bad_range)                              return 2'd1;
        else                                             return 2'd0;
    endfunction

    // Scatter the immediate into the format's fields; other bits come from base.
    function automatic logic [31:0] pack(input logic [2:0] fmt, input logic [31:0] imm,
                                         input logic [31:0] base);
        case (fmt)
            3'd0:    return {imm[11:0], base[19:0]};
            3'd1:    return {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            3'd2:    return {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            3'd3:    return {imm[31:12], base[11:0]};
            3'd4:    return {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
            default: return base;
        endcase
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_fmt_q, s1_fmt_d;
    logic [31:0]      s1_imm_q, s1_imm_d;
    logic [31:0]      s1_base_q, s1_base_d;
    logic [1:0]       s1_code_q, s1_code_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic s2_adv, s1_adv, in_ready, accept;

    // Handshake decisions and next-state for both stages and the error counter.
    always_comb begin
        s2_adv   = !s2_valid_q || bus.OUT_READY;
        s1_adv   = s1_valid_q && s2_adv;
        in_ready = RST_N && (!s1_valid_q || s2_adv);
        accept   = bus.IN_VALID && in_ready;

        s1_valid_d  = s1_valid_q;
        s1_fmt_d    = s1_fmt_q;
        s1_imm_d    = s1_imm_q;
        s1_base_d   = s1_base_q;
        s1_code_d   = s1_code_q;
        s2_valid_d  = s2_valid_q;
        instr_d     = instr_q;
        err_d       = err_q;
        code_d      = code_q;
        err_count_d = err_count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_fmt_d   = bus.FMT;
            s1_imm_d   = bus.IMM;
            s1_base_d  = bus.BASE;
            s1_code_d  = calc_code(bus.FMT, bus.IMM);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            err_d      = (s1_code_q != 2'd0);
            code_d     = s1_code_q;
            instr_d    = (s1_code_q != 2'd0) ? NOP_INSTR : pack(s1_fmt_q, s1_imm_q, s1_base_q);
        end else if (bus.OUT_READY) begin
            s2_valid_d = 1'b0;
        end

        // Counted at the consume edge only, so a stalled result counts once.
        if (s2_valid_q && bus.OUT_READY && err_q && (err_count_q != {CNT_W{1'b1}}))
            err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // State registers; reset drops anything in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= 3'd0;
            s1_imm_q    <= 32'd0;
            s1_base_q   <= 32'd0;
            s1_code_q   <= 2'd0;
            s2_valid_q  <= 1'b0;
            instr_q     <= 32'd0;
            err_q       <= 1'b0;
            code_q      <= 2'd0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_imm_q    <= s1_imm_d;
            s1_base_q   <= s1_base_d;
            s1_code_q   <= s1_code_d;
            s2_valid_q  <= s2_valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            code_q      <= code_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = s2_valid_q;
    assign bus.INSTRUCT  = instr_q;
    assign bus.ERR       = err_q;
    assign bus.ERR_CODE  = code_q;
    assign bus.ERR_COUNT = err_count_q;
endmodule

// File: tb/tb_immed_encoder.sv
// Bench for immed_encoder: directed cases, backpressure, reset, counter
// saturation (second instance with a 2-bit counter) and a random round-trip run.
module tb_immed_encoder;
    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    immed_encoder_if #(.CNT_W(16)) bus ();
    immed_encoder_if #(.CNT_W(2))  bus2 ();

    immed_encoder #(.CNT_W(16)) dut  (.CLK(CLK), .RST_N(RST_N), .bus(bus));
    immed_encoder #(.CNT_W(2))  dut2 (.CLK(CLK), .RST_N(RST_N), .bus(bus2));

    int n_pass = 0;
    int n_total = 0;
    int n_accept = 0;
    int n_consume = 0;
    int model_cnt = 0;
    logic [66:0] exp_q[$];   // {fmt, imm, base}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Error code from the numeric meaning of the immediate.
    function automatic logic [1:0] model_code(input logic [2:0] fmt, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        if (fmt > 3'd4) return 2'd3;
        if ((fmt == 3'd2 || fmt == 3'd4) && (imm % 2 != 0)) return 2'd2;
        case (fmt)
            3'd0, 3'd1: if (s < -2048 || s > 2047) return 2'd1;
            3'd2:       if (s < -4096 || s > 4095) return 2'd1;
            3'd4:       if (s < -(64'sd1 << 20) || s >= (64'sd1 << 20)) return 2'd1;
            default:    if (imm % 4096 != 0) return 2'd1;
        endcase
        return 2'd0;
    endfunction

    // The core's immediate generator: recovers the immediate from an instruction.
    function automatic logic [31:0] decode(input logic [2:0] fmt, input logic [31:0] i);
        case (fmt)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    // Instruction bits that hold the immediate in each format.
    function automatic logic [31:0] imm_mask(input logic [2:0] fmt);
        case (fmt)
            3'd0:       return 32'hFFF0_0000;
            3'd1, 3'd2: return 32'hFE00_0F80;
            default:    return 32'hFFFF_F000;
        endcase
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge CLK) begin
        logic [2:0]  f;
        logic [31:0] im, b;
        logic [1:0]  c;
        if (!RST_N) begin
            check("in_ready_during_reset", {31'd0, bus.IN_READY}, 32'd0);
            exp_q.delete();
            model_cnt = 0;
        end else begin
            check("err_count", {16'd0, bus.ERR_COUNT}, model_cnt);
            if (bus.OUT_VALID) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_with_nothing_expected", {31'd0, bus.OUT_VALID}, 32'd0);
                end else begin
                    {f, im, b} = exp_q[0];
                    c = model_code(f, im);
                    check("err", {31'd0, bus.ERR}, {31'd0, c != 2'd0});
                    check("err_code", {30'd0, bus.ERR_CODE}, {30'd0, c});
                    if (c != 2'd0) begin
                        check("err_instr", bus.INSTRUCT, 32'h0000_0013);
                    end else begin
                        check("round_trip", decode(f, bus.INSTRUCT), im);
                        check("base_bits", bus.INSTRUCT & ~imm_mask(f), b & ~imm_mask(f));
                    end
                    if (bus.OUT_READY) begin
                        void'(exp_q.pop_front());
                        n_consume++;
                        if (c != 2'd0 && model_cnt < 65535) model_cnt++;
                    end
                end
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                exp_q.push_back({bus.FMT, bus.IMM, bus.BASE});
                n_accept++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] f, input logic [31:0] i, input logic [31:0] b);
        bus.FMT = f;
        bus.IMM = i;
        bus.BASE = b;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST_N = 1'b0;
        bus.IN_VALID = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
    endtask

    // Single request on an idle pipeline with OUT_READY=1; reports latency.
    task automatic req_lat(input logic [2:0] f, input logic [31:0] i, input logic [31:0] b,
                           output int lat, output logic [31:0] instr,
                           output logic err, output logic [1:0] code);
        bit got;
        @(posedge CLK); #1;
        drive(f, i, b);
        bus.IN_VALID = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.IN_READY) begin got = 1; break; end
        end
        if (!got) check("accept_timeout", {31'd0, bus.IN_READY}, 32'd1);
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        lat = 0; instr = 32'hx; err = 1'bx; code = 2'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (bus.OUT_VALID) begin
                lat = k; instr = bus.INSTRUCT; err = bus.ERR; code = bus.ERR_CODE;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: r = r;
            1: r = {{20{r[11]}}, r[11:0]};
            2: r = {{19{r[12]}}, r[12:0]};
            3: r = {{11{r[20]}}, r[20:0]};
            default: r = {r[31:12], 12'd0};
        endcase
        if ($urandom_range(0, 3) != 0) r[0] = 1'b0;
        return r;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        logic [31:0] instr;
        logic err;
        logic [1:0] code;
        int base_consume, base_accept, cyc, consumed2;
        bit done;

        bus.IN_VALID = 0; bus.OUT_READY = 1; drive(3'd0, 32'd0, 32'd0);
        bus2.IN_VALID = 0; bus2.OUT_READY = 1; bus2.FMT = 0; bus2.IMM = 0; bus2.BASE = 0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("reset_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check("reset_instr", bus.INSTRUCT, 32'd0);
        check("reset_err", {31'd0, bus.ERR}, 32'd0);
        check("reset_err_code", {30'd0, bus.ERR_CODE}, 32'd0);
        check("reset_err_count", {16'd0, bus.ERR_COUNT}, 32'd0);

        // 1: I-format, latency, then out of range
        req_lat(3'd0, 32'hFFFF_F800, 32'h0000_0013, lat, instr, err, code);
        check("t1_latency", lat, 2);
        check("t1_instr", instr, 32'h8000_0013);
        check("t1_err", {31'd0, err}, 32'd0);
        req_lat(3'd0, 32'h0000_0800, 32'h0000_0013, lat, instr, err, code);
        check("t1_range_err", {31'd0, err}, 32'd1);
        check("t1_range_code", {30'd0, code}, 32'd1);
        check("t1_range_instr", instr, 32'h0000_0013);

        // 2: B and U packing
        req_lat(3'd2, 32'h0000_0FFE, 32'h0000_0063, lat, instr, err, code);
        check("t2_b_instr", instr, 32'h7E00_0FE3);
        req_lat(3'd3, 32'h1234_5000, 32'h0000_0537, lat, instr, err, code);
        check("t2_u_instr", instr, 32'h1234_5537);

        // 3: error codes and counter
        do_reset();
        req_lat(3'd4, 32'h0000_0001, 32'h0000_006F, lat, instr, err, code);
        check("t3_j_misaligned", {30'd0, code}, 32'd2);
        req_lat(3'd7, $urandom, 32'h0000_0013, lat, instr, err, code);
        check("t3_bad_fmt", {30'd0, code}, 32'd3);
        req_lat(3'd2, 32'h0000_1001, 32'h0000_0063, lat, instr, err, code);
        check("t3_misaligned_first", {30'd0, code}, 32'd2);
        @(negedge CLK);
        check("t3_err_count", {16'd0, bus.ERR_COUNT}, 32'd3);

        // 4: backpressure
        base_consume = n_consume;
        @(posedge CLK); #1;
        bus.OUT_READY = 1'b0;
        drive(3'd0, 32'd1, 32'h0000_0013); bus.IN_VALID = 1'b1;
        @(negedge CLK); check("t4_ready_first", {31'd0, bus.IN_READY}, 32'd1);
        @(posedge CLK); #1 drive(3'd1, 32'hFFFF_FFF0, 32'h0000_0023);
        @(negedge CLK); check("t4_ready_second", {31'd0, bus.IN_READY}, 32'd1);
        @(posedge CLK); #1 drive(3'd3, 32'hABCD_E000, 32'h0000_00B7);
        @(negedge CLK); check("t4_ready_third_blocked", {31'd0, bus.IN_READY}, 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK); check("t4_still_blocked", {31'd0, bus.IN_READY}, 32'd0);
        @(posedge CLK); #1 bus.OUT_READY = 1'b1;
        @(negedge CLK); check("t4_third_on_release", {31'd0, bus.IN_READY}, 32'd1);
        @(posedge CLK); #1 bus.IN_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK); #1;
        check("t4_consumed", n_consume - base_consume, 3);
        check("t4_drained", exp_q.size(), 0);

        // 5: reset with two in flight
        @(posedge CLK); #1;
        bus.OUT_READY = 1'b0;
        drive(3'd0, 32'd5, 32'h0000_0013); bus.IN_VALID = 1'b1;
        @(posedge CLK); #1 drive(3'd0, 32'd6, 32'h0000_0013);
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        RST_N = 1'b0;
        @(negedge CLK); check("t5_ready_in_reset", {31'd0, bus.IN_READY}, 32'd0);
        @(posedge CLK); #1 RST_N = 1'b1;
        @(negedge CLK);
        check("t5_out_valid_cleared", {31'd0, bus.OUT_VALID}, 32'd0);
        check("t5_err_count_cleared", {16'd0, bus.ERR_COUNT}, 32'd0);
        bus.OUT_READY = 1'b1;
        req_lat(3'd1, 32'h0000_07FF, 32'h0000_0023, lat, instr, err, code);
        check("t5_latency_after_reset", lat, 2);
        check("t5_instr", instr, 32'h7E00_0FA3);

        // 6a: saturation on the 2-bit counter instance
        @(posedge CLK); #1;
        bus2.FMT = 3'd7; bus2.IN_VALID = 1'b1; bus2.OUT_READY = 1'b1;
        consumed2 = 0;
        for (int k = 0; k < 50 && consumed2 < 5; k++) begin
            @(negedge CLK);
            check("sat_count", {30'd0, bus2.ERR_COUNT}, (consumed2 > 3) ? 3 : consumed2);
            if (bus2.OUT_VALID && bus2.OUT_READY) consumed2++;
        end
        check("sat_consumed", consumed2, 5);
        @(posedge CLK); #1 bus2.IN_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        check("sat_final", {30'd0, bus2.ERR_COUNT}, 32'd3);

        // 6b: random round trip with random backpressure
        base_accept = n_accept;
        cyc = 0;
        done = 0;
        while (!done) begin
            @(posedge CLK); #1;
            bus.IN_VALID = ($urandom_range(0, 3) != 0);
            bus.OUT_READY = ($urandom_range(0, 3) != 0);
            begin
                int r;
                r = $urandom_range(0, 15);
                bus.FMT = (r < 14) ? 3'(r % 5) : 3'(5 + r % 3);
            end
            bus.IMM = rand_imm();
            bus.BASE = $urandom;
            cyc++;
            if (n_accept - base_accept >= 10000 || cyc >= 60000) done = 1;
        end
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("rand_accepted", (n_accept - base_accept >= 10000), 1);
        check("rand_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
